// File: rtl/cpu_pkg.sv
// Shared definitions for the mini CPU pipeline: fetch FSM states,
// instruction width, reset PC default and the NOP encoding.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = '0;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        FS_REQ,
        FS_WAIT,
        FS_HOLD,
        FS_DROP
    } fetch_state_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus; master is the fetch stage,
// slave is the instruction memory.
interface if_fetch_stage_if;
    import cpu_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_stage_pc_gen.sv
// Program counter: redirect load (word aligned) has priority over the
// sequential +4 step, which wraps silently at the top of the address space.
module pc_gen
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= align_pc(redirect_pc);
        end else if (advance) begin
            pc <= pc + PC_STEP;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: one outstanding imem request, skid register for
// a response arriving under stall, redirect flush with stale-response drop.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] NOP_WORD = NOP_INSTR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [XLEN-1:0]          redirect_pc,
    if_fetch_stage_if.master         imem,
    output logic [XLEN-1:0]          value,
    output logic [XLEN-1:0]          pc_out,
    output logic                     instr_valid
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] skid;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] redirect_tgt;
    logic            accept;
    logic            resp;
    logic            pc_advance;
    logic            keep_outstanding;

    assign imem.imem_req  = (state == FS_REQ) && !rst;
    assign imem.imem_addr = pc;

    assign accept       = imem.imem_req && imem.imem_ready;
    assign resp         = (state == FS_WAIT) && imem.imem_rvalid;
    assign pc_advance   = resp && !redirect;
    assign redirect_tgt = align_pc(redirect_pc);

    // A request is still in flight after redirect if one was just accepted
    // or a WAIT/DROP response has not yet arrived.
    assign keep_outstanding = ((state == FS_WAIT) && !imem.imem_rvalid) ||
                              ((state == FS_REQ)  && accept) ||
                              ((state == FS_DROP) && !imem.imem_rvalid);

    pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .advance     (pc_advance),
        .pc          (pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FS_REQ;
            value       <= NOP_WORD;
            pc_out      <= RESET_PC;
            instr_valid <= 1'b0;
            skid        <= '0;
            skid_pc     <= RESET_PC;
        end else if (redirect) begin
            value       <= NOP_WORD;
            instr_valid <= 1'b0;
            pc_out      <= redirect_tgt;
            skid        <= '0;
            state       <= keep_outstanding ? FS_DROP : FS_REQ;
        end else begin
            // Downstream consumed the word: bubble unless a new one loads below.
            if (!stall) begin
                value       <= NOP_WORD;
                instr_valid <= 1'b0;
            end
            unique case (state)
                FS_REQ: begin
                    if (accept) begin
                        state <= FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (stall) begin
                            skid    <= imem.imem_rdata;
                            skid_pc <= pc;
                            state   <= FS_HOLD;
                        end else begin
                            value       <= imem.imem_rdata;
                            pc_out      <= pc;
                            instr_valid <= 1'b1;
                            state       <= FS_REQ;
                        end
                    end
                end
                FS_HOLD: begin
                    if (!stall) begin
                        value       <= skid;
                        pc_out      <= skid_pc;
                        instr_valid <= 1'b1;
                        state       <= FS_REQ;
                    end
                end
                FS_DROP: begin
                    if (imem.imem_rvalid) begin
                        state <= FS_REQ;
                    end
                end
            endcase
        end
    end

endmodule
